// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: pops little-endian 16-bit stereo PCM bytes from the WAV byte
// FIFO, assembles left/right samples and serialises them as I2S towards a
// WM8731 DAC that is bit-clock and LR-clock master.
//
// Handshake: fifo_rd_en is a one-cycle read strobe, only ever raised while
// fifo_empty = 0; the byte appears on fifo_rd_data the cycle after, and at
// most one read is outstanding. sample_valid is a one-cycle pulse with
// left_data/right_data stable from that cycle until the next pulse.
`timescale 1ns/1ps
module i2s_dac_tx #(
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [7:0]             fifo_rd_data,
    input  logic                   bclk,
    input  logic                   daclrc,
    output logic                   dacdat,
    output logic                   sample_valid,
    output logic [SAMPLE_BITS-1:0] left_data,
    output logic [SAMPLE_BITS-1:0] right_data,
    output logic [15:0]            underrun_cnt
);

    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_REQ  = 2'd1;
    localparam logic [1:0] F_CAP  = 2'd2;

    localparam logic [4:0] WORD_BITS = 5'(SAMPLE_BITS);

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrc_sync;
    logic                   bclk_q;
    logic                   lrc_q;
    logic                   bclk_fall;
    logic                   lrc_fall;
    logic                   lrc_rise;

    logic [1:0]             f_state;
    logic [1:0]             byte_idx;
    logic [7:0]             l_lo, l_hi, r_lo, r_hi;
    logic                   buf_full;
    logic                   frame_take;

    logic [SAMPLE_BITS-1:0] shift_reg;
    logic [SAMPLE_BITS-1:0] right_hold;
    logic [4:0]             bit_cnt;

    // Bring the codec clocks into the clk domain and keep one delayed copy for edges
    always_ff @(posedge clk) begin
        if (!rst) begin
            bclk_sync <= '0;
            lrc_sync  <= '0;
            bclk_q    <= 1'b0;
            lrc_q     <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrc_sync  <= {lrc_sync[SYNC_STAGES-2:0], daclrc};
            bclk_q    <= bclk_sync[SYNC_STAGES-1];
            lrc_q     <= lrc_sync[SYNC_STAGES-1];
        end
    end

    assign bclk_fall  = bclk_q & ~bclk_sync[SYNC_STAGES-1];
    assign lrc_fall   = lrc_q & ~lrc_sync[SYNC_STAGES-1];
    assign lrc_rise   = ~lrc_q & lrc_sync[SYNC_STAGES-1];

    // A buffered sample is consumed only by a left-frame start while playing
    assign frame_take = lrc_fall & buf_full & enable;

    // Read strobe is decoded from the fetch state so it can never outlive fifo_empty
    assign fifo_rd_en = (f_state == F_REQ) && enable && !fifo_empty;

    // Fetch FSM: four single reads L_lo, L_hi, R_lo, R_hi into the sample buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            f_state  <= F_IDLE;
            byte_idx <= 2'd0;
            l_lo     <= 8'd0;
            l_hi     <= 8'd0;
            r_lo     <= 8'd0;
            r_hi     <= 8'd0;
            buf_full <= 1'b0;
        end else begin
            case (f_state)
                F_IDLE: begin
                    if (enable && !buf_full) begin
                        f_state  <= F_REQ;
                        byte_idx <= 2'd0;
                    end
                end
                F_REQ: begin
                    if (!enable) begin
                        f_state <= F_IDLE;
                    end else if (!fifo_empty) begin
                        f_state <= F_CAP;
                    end
                end
                F_CAP: begin
                    case (byte_idx)
                        2'd0:    l_lo <= fifo_rd_data;
                        2'd1:    l_hi <= fifo_rd_data;
                        2'd2:    r_lo <= fifo_rd_data;
                        default: r_hi <= fifo_rd_data;
                    endcase
                    if (byte_idx == 2'd3) begin
                        f_state <= F_IDLE;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        f_state  <= F_REQ;
                    end
                end
                default: f_state <= F_IDLE;
            endcase

            // Fetch only runs while the buffer is empty, so set and clear never collide
            if (f_state == F_CAP && byte_idx == 2'd3) begin
                buf_full <= 1'b1;
            end else if (frame_take) begin
                buf_full <= 1'b0;
            end
        end
    end

    // Frame load on LR edges and MSB-first shifting on bclk falls
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_reg    <= '0;
            right_hold   <= '0;
            bit_cnt      <= 5'd0;
            dacdat       <= 1'b0;
            sample_valid <= 1'b0;
            left_data    <= '0;
            right_data   <= '0;
            underrun_cnt <= 16'd0;
        end else begin
            sample_valid <= 1'b0;
            if (lrc_fall) begin
                if (frame_take) begin
                    left_data    <= {l_hi, l_lo};
                    right_data   <= {r_hi, r_lo};
                    shift_reg    <= {l_hi, l_lo};
                    right_hold   <= {r_hi, r_lo};
                    sample_valid <= 1'b1;
                end else begin
                    shift_reg  <= '0;
                    right_hold <= '0;
                    if (enable && underrun_cnt != 16'hFFFF) begin
                        underrun_cnt <= underrun_cnt + 16'd1;
                    end
                end
                bit_cnt <= 5'd0;
                // The bclk fall that carries the LR transition is the I2S delay slot
                if (bclk_fall) begin
                    dacdat <= 1'b0;
                end
            end else if (lrc_rise) begin
                shift_reg <= right_hold;
                bit_cnt   <= 5'd0;
                if (bclk_fall) begin
                    dacdat <= 1'b0;
                end
            end else if (bclk_fall) begin
                if (bit_cnt < WORD_BITS) begin
                    dacdat    <= shift_reg[SAMPLE_BITS-1];
                    shift_reg <= {shift_reg[SAMPLE_BITS-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + 5'd1;
                end else begin
                    dacdat <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Downstream consumer of the WAV byte FIFO that the SD-card WAV reader fills.
- Pops raw little-endian 16-bit stereo PCM bytes and assembles them into left/right samples.
- Serialises the samples as I2S onto the WM8731 DAC data pin; the codec is bit-clock and LR-clock master.
- Also presents each assembled stereo sample to the FFT/visualiser stage.

Parameters:
- SAMPLE_BITS, 16, bits per channel; fixed at 16, other values unsupported.
- SYNC_STAGES, 2, synchroniser depth for the codec bclk/daclrc inputs; legal values 2..3.

Ports:
- clk  in  1  system clock, at least 8x bclk.
- rst  in  1  synchronous active-low reset.
- enable  in  1  1 = play, 0 = output silence and stop popping the FIFO.
- fifo_empty  in  1  byte FIFO empty flag.
- fifo_rd_en  out  1  FIFO read request; data is valid on fifo_rd_data one cycle later (normal, non-show-ahead FIFO).
- fifo_rd_data  in  8  FIFO read data.
- bclk  in  1  codec bit clock, asynchronous.
- daclrc  in  1  codec DAC LR clock, asynchronous; 0 = left, 1 = right.
- dacdat  out  1  I2S serial data to codec.
- sample_valid  out  1  one-cycle pulse when a new stereo sample is loaded for transmission.
- left_data  out  16  left sample loaded at sample_valid.
- right_data  out  16  right sample loaded at sample_valid.
- underrun_cnt  out  16  frames sent as silence because no sample was buffered; saturates at 0xFFFF.

Behaviour:
- Reset (rst = 0 at a clk edge) sets: fifo_rd_en = 0, dacdat = 0, sample_valid = 0, left_data = 0, right_data = 0, underrun_cnt = 0, fetch FSM = F_IDLE, buffer empty, shift registers = 0, synchronisers = 0. Reset has priority over every other event, including mid-frame and mid-fetch.
- bclk and daclrc each pass through SYNC_STAGES flops.
- Edge detects on the synchronised signals: bclk_fall, bclk_rise, lrc_fall (1->0, left-frame start), lrc_rise (0->1, right-frame start).
- Fetch FSM, byte order in the FIFO is L_lo, L_hi, R_lo, R_hi:
  - F_IDLE: if enable and buffer empty -> F_REQ, byte index = 0.
  - F_REQ: if fifo_empty = 0, assert fifo_rd_en for exactly one cycle -> F_CAP; else hold in F_REQ. If enable drops -> F_IDLE.
  - F_CAP: capture fifo_rd_data into byte[index]. If index = 3, set buffer full -> F_IDLE; else index++ -> F_REQ.
  - At most one outstanding read at any time; fifo_rd_en is never asserted while fifo_empty = 1.
  - A partially fetched sample is kept while fetching stalls on an empty FIFO.
- Frame load on lrc_fall:
  - Buffer full and enable = 1: copy {L_hi, L_lo} to left_data and the left shift register, {R_hi, R_lo} to right_data and the right holding register; clear buffer full; pulse sample_valid for 1 cycle.
  - Buffer empty or enable = 0: load zeros into both; no sample_valid.
  - Buffer empty and enable = 1: additionally increment underrun_cnt (saturating).
  - lrc_fall and F_CAP setting buffer full in the same cycle: the buffer state before that cycle decides the load. The just-completed sample stays buffered for the next frame.
- Serial output, I2S format, MSB first:
  - On the first bclk_fall after an LR edge, dacdat = MSB of the current channel (one-bclk delay after the LR transition).
  - Each following bclk_fall shifts out the next bit.
  - After 16 bits, dacdat = 0 until the next LR edge.
  - lrc_rise moves the right holding register into the shift register and restarts the bit counter.
  - An LR edge arriving before 16 bits are sent restarts the count; no error is flagged.
- Latency: dacdat changes 1 clk after the synchronised bclk_fall is detected, i.e. SYNC_STAGES+1 clk after the raw bclk edge.
- Arithmetic: samples are two's-complement and passed through unmodified; bit counter is 5 bits.

Test Plan:
- Reset mid-fetch (after 2 bytes popped), then release -> all outputs 0, underrun_cnt = 0, next fetch pops 4 fresh bytes starting at L_lo.
- FIFO bytes 0x34,0x12,0xCD,0xAB, enable = 1, bclk = 64x Fs -> sample_valid pulse with left_data = 0x1234, right_data = 0xABCD; serial left word 0001001000110100 starts 1 bclk after daclrc falls, right word 1010101111001101 after daclrc rises.
- FIFO empty throughout, 5 frames -> dacdat all 0, underrun_cnt = 5, fifo_rd_en never asserted.
- FIFO runs dry after 2 bytes, refilled 3 frames later -> 3 silent frames (underrun_cnt = 3), then the correct sample assembled from bytes 1-4 with no byte loss.
- enable = 0 with a full FIFO -> no pops, silence, underrun_cnt unchanged; re-enable -> playback resumes at the next lrc_fall.
- underrun_cnt preloaded by forcing 65535 empty frames -> stays at 0xFFFF on the next underrun.
